// File: rtl/stim_match_counter.sv
// Stimulus run counter with per-channel compare/match detection.
// A run counts 0..TERMINAL, then either wraps (tracking the number of
// wraps) or parks in DONE. Each compare channel flags a combinational
// match pulse while running and latches it into a sticky flag.
module stim_match_counter #(
    parameter int WIDTH    = 32,
    parameter int NCMP     = 4,
    parameter int TERMINAL = 99,
    localparam int CIDX    = (NCMP > 1) ? $clog2(NCMP) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             wrap_mode,
    input  logic             cmp_wr,
    input  logic [CIDX-1:0]  cmp_idx,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             hit_clr,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic [NCMP-1:0]  hit_pulse,
    output logic [NCMP-1:0]  hit_sticky,
    output logic [7:0]       wrap_cnt
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;

    // State register together with the run counter and wrap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    // Next-state and counter update; stop outranks start and terminal handling.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wrap_cnt_d = wrap_cnt_q;
        if (stop) begin
            // Abort keeps count and wrap_cnt so software can read where it stopped.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d    = S_RUN;
                        count_d    = '0;
                        wrap_cnt_d = '0;
                    end
                end
                S_RUN: begin
                    if (count_q == TERM) begin
                        if (wrap_mode) begin
                            count_d = '0;
                            if (wrap_cnt_q != 8'hFF) begin
                                wrap_cnt_d = wrap_cnt_q + 8'd1;
                            end
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs decode the registered state only.
    always_comb begin
        running  = (state_q == S_RUN);
        done     = (state_q == S_DONE);
        count    = count_q;
        wrap_cnt = wrap_cnt_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCMP; gi++) begin : g_ch
            logic [WIDTH-1:0] cmp_q, cmp_d;
            logic             valid_q, valid_d;
            logic             sticky_q, sticky_d;
            logic             wr_sel;

            // Out-of-range indices simply match no channel.
            assign wr_sel        = cmp_wr && (cmp_idx == CIDX'(gi));
            // Match uses the stored compare value, not a same-cycle write.
            assign hit_pulse[gi]  = running && valid_q && (count_q == cmp_q);
            assign hit_sticky[gi] = sticky_q;

            // Compare register write and sticky update (a new hit beats hit_clr).
            always_comb begin
                cmp_d    = cmp_q;
                valid_d  = valid_q;
                if (wr_sel) begin
                    cmp_d   = cmp_val;
                    valid_d = 1'b1;
                end
                sticky_d = hit_pulse[gi] | (sticky_q & ~hit_clr);
            end

            // Per-channel compare, valid and sticky registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cmp_q    <= '0;
                    valid_q  <= 1'b0;
                    sticky_q <= 1'b0;
                end else begin
                    cmp_q    <= cmp_d;
                    valid_q  <= valid_d;
                    sticky_q <= sticky_d;
                end
            end
        end
    endgenerate

endmodule

// File: doc/stim_match_counter.md
STIM_MATCH_COUNTER -- requirements
Module: stim_match_counter

Interface
REQ-001 Parameter WIDTH, 32, counter and compare-value width (2..64).
REQ-002 Parameter NCMP, 4, number of compare channels (1..16).
REQ-003 Parameter TERMINAL, 99, final count value of a run; SHALL be < 2^WIDTH.
REQ-004 Local CIDX = (NCMP>1) ? clog2(NCMP) : 1.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin a run from IDLE or DONE.
REQ-008 stop  input  1  abort run; return to IDLE.
REQ-009 wrap_mode  input  1  1: wrap to 0 at TERMINAL and keep running; 0: stop in DONE.
REQ-010 cmp_wr  input  1  write compare register cmp_idx.
REQ-011 cmp_idx  input  CIDX  compare channel select; cmp_idx >= NCMP ignored.
REQ-012 cmp_val  input  WIDTH  compare value to write.
REQ-013 hit_clr  input  1  clear all sticky hit flags.
REQ-014 count  output  WIDTH  current count.
REQ-015 running  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.
REQ-017 hit_pulse  output  NCMP  per-channel match this cycle.
REQ-018 hit_sticky  output  NCMP  per-channel latched match.
REQ-019 wrap_cnt  output  8  wraps in current run, saturating at 255.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DONE; running=(RUN), done=(DONE), both registered-state decodes.
REQ-021 IDLE: count holds; start -> RUN with count<=0 and wrap_cnt<=0.
REQ-022 RUN, count!=TERMINAL: count<=count+1 each cycle.
REQ-023 RUN, count==TERMINAL, wrap_mode=1: count<=0, wrap_cnt<=min(wrap_cnt+1,255), stay RUN.
REQ-024 RUN, count==TERMINAL, wrap_mode=0: -> DONE, count holds TERMINAL.
REQ-025 DONE: count holds; start -> RUN with count<=0, wrap_cnt<=0.
REQ-026 stop in RUN or DONE -> IDLE, count and wrap_cnt hold; stop SHALL take priority over start and over terminal handling.
REQ-027 start while in RUN SHALL be ignored.
REQ-028 TERMINAL=0: each RUN cycle is terminal (count stays 0; wrap_cnt increments or DONE next cycle).
REQ-029 Each channel i holds cmp[i] (WIDTH bits) and valid[i]; cmp_wr writes cmp[cmp_idx]<=cmp_val, valid[cmp_idx]<=1.
REQ-030 hit_pulse[i] SHALL be combinational: running && valid[i] && count==cmp[i]; uses register value before any same-cycle write.
REQ-031 hit_sticky[i] SHALL set on the edge ending a cycle with hit_pulse[i]=1, visible next cycle; cleared by hit_clr; set wins over simultaneous hit_clr.
REQ-032 start and stop SHALL NOT clear hit_sticky or compare registers.
REQ-033 cmp[i] >= 2^WIDTH unreachable not applicable; cmp[i] > TERMINAL SHALL never hit.

Reset
REQ-034 On reset: state IDLE, count=0, wrap_cnt=0, all cmp=0, all valid=0, hit_sticky=0; running=done=0, hit_pulse=0.
REQ-035 reset SHALL override all other inputs in the same cycle, including mid-run.

Verification
REQ-036 Defaults, wrap_mode=0, cmp[0]=30, cmp[1]=300, start 1 cycle -> count 0..99 over 100 cycles, hit_pulse[0] exactly once at count 30, hit_pulse[1] never, then done=1 with count=99 held.
REQ-037 wrap_mode=1, TERMINAL=99, run 250 cycles -> count sequence 0..99,0..99,0..49, wrap_cnt=2, hit_sticky[0] set after first count 30.
REQ-038 stop and start asserted together at count 40 -> IDLE, count holds 40, running=0; later start -> count restarts at 0.
REQ-039 hit_clr asserted in same cycle as hit_pulse[2] -> hit_sticky[2]=1 next cycle; hit_clr alone next -> 0.
REQ-040 reset asserted at count 57 in RUN -> next cycle IDLE, count=0, hit_sticky=0, valid=0 (no hit_pulse on subsequent run until cmp rewritten).
